// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter: 2*CPUS cache ports onto one RAM port.
// Optional MEM_ARB_DATA_PRIORITY_EN: data ports arbitrate first.
module mem_arbiter_rr #(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*ADDR_W-1:0] daddr,
  input  logic [CPUS*DATA_W-1:0] dstore,
  input  logic [CPUS*ADDR_W-1:0] iaddr,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS-1:0]        iwait,
  output logic [DATA_W-1:0]      dload,
  output logic [DATA_W-1:0]      iload,
  input  logic [1:0]             ramstate,
  input  logic [DATA_W-1:0]      ramload,
  output logic [ADDR_W-1:0]      ramaddr,
  output logic [DATA_W-1:0]      ramstore,
  output logic                   ramREN,
  output logic                   ramWEN
);

  localparam int N  = 2 * CPUS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    FREE, BUSY, ACCESS, ERROR
  } ramstate_t;

  typedef enum logic {
    IDLE, GRANT
  } state_t;

  state_t        st_q, st_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] rr_q, rr_d;

  logic [N-1:0]  req;
  logic [IW-1:0] pick;
  logic [IW-1:0] rr_nxt;
  logic          live;
  logic          done;
  logic          g_is_i;
  int            gc;

  // First set request at or after ptr, modulo N; optionally even only.
  function automatic logic [IW-1:0] rr_pick(
    input logic [N-1:0]  r,
    input logic [IW-1:0] ptr,
    input logic          data_only
  );
    logic [IW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && r[idx] && (!data_only || (idx % 2) == 0)) begin
        sel   = IW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Interleave cache ports into one request vector.
  always_comb begin
    req = '0;
    for (int c = 0; c < CPUS; c++) begin
      req[2*c]   = dREN[c] | dWEN[c];
      req[2*c+1] = iREN[c];
    end
  end

  // Choose the next winner from the current pointer.
  always_comb begin
`ifdef MEM_ARB_DATA_PRIORITY_EN
    if (|(dREN | dWEN)) begin
      pick = rr_pick(req, rr_q, 1'b1);
    end else begin
      pick = rr_pick(req, rr_q, 1'b0);
    end
`else
    pick = rr_pick(req, rr_q, 1'b0);
`endif
  end

  // Decode the held grant into cache index and port kind.
  always_comb begin
    gc     = int'(gnt_q) / 2;
    g_is_i = gnt_q[0];
    live   = req[gnt_q];
    done   = (st_q == GRANT) && live &&
             (ramstate_t'(ramstate) == ACCESS);
    if (gnt_q == IW'(N - 1)) begin
      rr_nxt = '0;
    end else begin
      rr_nxt = gnt_q + 1'b1;
    end
  end

  // Next-state logic for the grant FSM and pointer.
  always_comb begin
    st_d  = st_q;
    gnt_d = gnt_q;
    rr_d  = rr_q;
    unique case (st_q)
      IDLE: begin
        if (|req) begin
          gnt_d = pick;
          st_d  = GRANT;
        end
      end
      GRANT: begin
        if (!live) begin
          st_d = IDLE;
        end else if (done) begin
          st_d = IDLE;
          rr_d = rr_nxt;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q  <= IDLE;
      gnt_q <= '0;
      rr_q  <= '0;
    end else begin
      st_q  <= st_d;
      gnt_q <= gnt_d;
      rr_q  <= rr_d;
    end
  end

  // RAM port mux and completion handshake for the granted port.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = daddr[0 +: ADDR_W];
    ramstore = dstore[0 +: DATA_W];
    dwait    = '1;
    iwait    = '1;
    if (RST) begin
      ramaddr  = '0;
      ramstore = '0;
    end else if (st_q == GRANT) begin
      ramstore = dstore[gc*DATA_W +: DATA_W];
      if (g_is_i) begin
        ramaddr = iaddr[gc*ADDR_W +: ADDR_W];
        ramREN  = live;
      end else begin
        ramaddr = daddr[gc*ADDR_W +: ADDR_W];
        ramREN  = live && dREN[gc];
        ramWEN  = live && !dREN[gc];
      end
      if (done) begin
        if (g_is_i) begin
          iwait[gc] = 1'b0;
        end else begin
          dwait[gc] = 1'b0;
        end
      end
    end
  end

  // Read data goes to every cache; waits qualify it.
  always_comb begin
    dload = ramload;
    iload = ramload;
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr with CPUS=2.
// Expected grants follow the round-robin order by hand.
module tb_mem_arbiter_rr;

  logic        CLK;
  logic        RST;
  logic [1:0]  dREN, dWEN, iREN;
  logic [63:0] daddr, dstore, iaddr;
  logic [1:0]  dwait, iwait;
  logic [31:0] dload, iload;
  logic [1:0]  ramstate;
  logic [31:0] ramload;
  logic [31:0] ramaddr, ramstore;
  logic        ramREN, ramWEN;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd2;

  mem_arbiter_rr #(.CPUS(2), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .dREN(dREN), .dWEN(dWEN), .iREN(iREN),
    .daddr(daddr), .dstore(dstore), .iaddr(iaddr),
    .dwait(dwait), .iwait(iwait),
    .dload(dload), .iload(iload),
    .ramstate(ramstate), .ramload(ramload),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramREN(ramREN), .ramWEN(ramWEN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic apply_reset();
    tick();
    RST = 1'b1;
    dREN = '0; dWEN = '0; iREN = '0;
    ramstate = FREE;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    dREN = 2'b11; dWEN = 2'b11; iREN = 2'b11;
    ramstate = ACCESS;
    for (int k = 0; k < 2; k++) begin
      tick();
      #1;
      n_tests++;
      if ({ramREN, ramWEN, dwait, iwait, ramaddr} !==
          {2'b00, 2'b11, 2'b11, 32'h0}) begin
        n_fail++;
        $display("FAIL reset_hold k=%0d got %b%b %b %b %h want 00 11 11 0",
                 k, ramREN, ramWEN, dwait, iwait, ramaddr);
      end
    end
    tick();
    RST = 1'b0;
    ramstate = FREE;
    #1;
    n_tests++;
    if ({ramREN, ramWEN, dwait, iwait, ramaddr} !==
        {2'b00, 2'b11, 2'b11, 32'h100}) begin
      n_fail++;
      $display("FAIL reset_idle got %b%b %b %b %h want 00 11 11 100",
               ramREN, ramWEN, dwait, iwait, ramaddr);
    end
    tick();
    ramstate = ACCESS;
    #1;
    n_tests++;
    if ({ramREN, ramWEN, dwait, iwait, ramaddr} !==
        {2'b10, 2'b10, 2'b11, 32'h100}) begin
      n_fail++;
      $display("FAIL reset_first_grant got %b%b %b %b %h want 10 10 11 100",
               ramREN, ramWEN, dwait, iwait, ramaddr);
    end
    tick();
    ramstate = FREE;
    dREN = '0; dWEN = '0; iREN = '0;
    #1;
    n_tests++;
    if ({ramREN, ramWEN, dwait, iwait} !== {2'b00, 2'b11, 2'b11}) begin
      n_fail++;
      $display("FAIL reset_after got %b%b %b %b want 00 11 11",
               ramREN, ramWEN, dwait, iwait);
    end
  endtask

  task automatic test_single_read();
    apply_reset();
    iaddr[63:32] = 32'h40;
    iREN = 2'b10;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 3) begin
        ramstate = ACCESS;
        ramload  = 32'hDEADBEEF;
      end else begin
        ramstate = (k == 1) ? FREE : 2'd1;
      end
      #1;
      n_tests++;
      if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h40}) begin
        n_fail++;
        $display("FAIL read_cmd k=%0d got %b%b %h want 10 40",
                 k, ramREN, ramWEN, ramaddr);
      end
      n_tests++;
      if ({dwait, iwait} !== {2'b11, (k == 3) ? 2'b01 : 2'b11}) begin
        n_fail++;
        $display("FAIL read_wait k=%0d got %b %b", k, dwait, iwait);
      end
    end
    n_tests++;
    if ({iload, dload} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL read_load got %h %h want deadbeef", iload, dload);
    end
    tick();
    ramstate = FREE;
    #1;
    n_tests++;
    if ({ramREN, iwait} !== {1'b0, 2'b11}) begin
      n_fail++;
      $display("FAIL read_bubble got %b %b want 0 11", ramREN, iwait);
    end
    iREN = '0;
    iaddr[63:32] = 32'h400;
  endtask

  task automatic test_write();
    apply_reset();
    dWEN = 2'b01;
    for (int k = 1; k <= 2; k++) begin
      tick();
      ramstate = (k == 2) ? ACCESS : FREE;
      #1;
      n_tests++;
      if ({ramREN, ramWEN, ramaddr, ramstore} !==
          {2'b01, 32'h100, 32'h12345678}) begin
        n_fail++;
        $display("FAIL write_cmd k=%0d got %b%b %h %h want 01 100 12345678",
                 k, ramREN, ramWEN, ramaddr, ramstore);
      end
      n_tests++;
      if (dwait !== ((k == 2) ? 2'b10 : 2'b11)) begin
        n_fail++;
        $display("FAIL write_wait k=%0d got %b", k, dwait);
      end
    end
    tick();
    ramstate = FREE;
    dWEN = '0;
    #1;
    n_tests++;
    if ({ramWEN, dwait} !== {1'b0, 2'b11}) begin
      n_fail++;
      $display("FAIL write_done got %b %b want 0 11", ramWEN, dwait);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] ea [4];
    logic [1:0]  edw [4];
    logic [1:0]  eiw [4];
    ea  = '{32'h100, 32'h200, 32'h300, 32'h400};
    edw = '{2'b10, 2'b11, 2'b01, 2'b11};
    eiw = '{2'b11, 2'b10, 2'b11, 2'b01};
    apply_reset();
    dREN = 2'b11; iREN = 2'b11;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++;
      if ({ramREN, ramWEN, dwait, iwait} !== {2'b00, 2'b11, 2'b11}) begin
        n_fail++;
        $display("FAIL rr_idle k=%0d got %b%b %b %b",
                 k, ramREN, ramWEN, dwait, iwait);
      end
      tick();
      ramstate = ACCESS;
      #1;
      n_tests++;
      if ({ramaddr, dwait, iwait} !== {ea[k%4], edw[k%4], eiw[k%4]}) begin
        n_fail++;
        $display("FAIL rr_grant k=%0d got %h %b %b want %h %b %b",
                 k, ramaddr, dwait, iwait, ea[k%4], edw[k%4], eiw[k%4]);
      end
      tick();
      ramstate = FREE;
    end
    dREN = '0; iREN = '0;
  endtask

  task automatic test_drop_and_reset();
    apply_reset();
    dREN = 2'b10;
    tick();
    #1;
    n_tests++;
    if ({ramREN, ramaddr} !== {1'b1, 32'h300}) begin
      n_fail++;
      $display("FAIL drop_grant got %b %h want 1 300", ramREN, ramaddr);
    end
    tick();
    dREN = '0;
    ramstate = ACCESS;
    #1;
    n_tests++;
    if ({ramREN, ramWEN, dwait} !== {2'b00, 2'b11}) begin
      n_fail++;
      $display("FAIL drop_nopulse got %b%b %b want 00 11",
               ramREN, ramWEN, dwait);
    end
    tick();
    ramstate = FREE;
    dREN = 2'b11; iREN = 2'b11;
    tick();
    #1;
    n_tests++;
    if (ramaddr !== 32'h100) begin
      n_fail++;
      $display("FAIL drop_rrptr got %h want 100", ramaddr);
    end
    apply_reset();
    dWEN = 2'b10;
    tick();
    #1;
    n_tests++;
    if ({ramWEN, ramaddr} !== {1'b1, 32'h300}) begin
      n_fail++;
      $display("FAIL rst_mid_grant got %b %h want 1 300", ramWEN, ramaddr);
    end
    tick();
    RST = 1'b1;
    ramstate = ACCESS;
    #1;
    n_tests++;
    if ({ramREN, ramWEN, dwait, ramaddr} !== {2'b00, 2'b11, 32'h0}) begin
      n_fail++;
      $display("FAIL rst_mid_force got %b%b %b %h want 00 11 0",
               ramREN, ramWEN, dwait, ramaddr);
    end
    tick();
    RST = 1'b0;
    ramstate = FREE;
    dWEN = '0;
    dREN = 2'b11; iREN = 2'b11;
    tick();
    #1;
    n_tests++;
    if ({ramREN, ramaddr} !== {1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL rst_mid_regrant got %b %h want 1 100", ramREN, ramaddr);
    end
    dREN = '0; iREN = '0;
  endtask

  task automatic test_priority();
    logic [31:0] a1, a2;
    logic [3:0]  w1, w2;
`ifdef MEM_ARB_DATA_PRIORITY_EN
    a1 = 32'h300; w1 = 4'b01_11;
    a2 = 32'h200; w2 = 4'b11_10;
`else
    a1 = 32'h200; w1 = 4'b11_10;
    a2 = 32'h300; w2 = 4'b01_11;
`endif
    apply_reset();
    iREN = 2'b01; dREN = 2'b10;
    tick();
    ramstate = ACCESS;
    #1;
    n_tests++;
    if ({ramREN, ramaddr, dwait, iwait} !== {1'b1, a1, w1}) begin
      n_fail++;
      $display("FAIL prio_first got %b %h %b %b want 1 %h %b",
               ramREN, ramaddr, dwait, iwait, a1, w1);
    end
    tick();
    ramstate = FREE;
    if (a1 == 32'h200) iREN = '0;
    else dREN = '0;
    tick();
    ramstate = ACCESS;
    #1;
    n_tests++;
    if ({ramREN, ramaddr, dwait, iwait} !== {1'b1, a2, w2}) begin
      n_fail++;
      $display("FAIL prio_second got %b %h %b %b want 1 %h %b",
               ramREN, ramaddr, dwait, iwait, a2, w2);
    end
    tick();
    ramstate = FREE;
    dREN = '0; iREN = '0;
  endtask

  initial begin
    RST = 1'b1;
    dREN = '0; dWEN = '0; iREN = '0;
    daddr  = {32'h300, 32'h100};
    iaddr  = {32'h400, 32'h200};
    dstore = {32'hBBBB0000, 32'h12345678};
    ramstate = FREE;
    ramload  = 32'h0;
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_drop_and_reset();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
